// File: rtl/dtree_seq_classifier.sv
// Sequential decision-tree ensemble classifier: walks a run-time-loadable node
// table one node per cycle, tallies leaf votes per tree and reports a strict-majority decision.
module dtree_seq_classifier #(
  parameter int N_FEAT     = 51,
  parameter int N_TREES    = 4,
  parameter int NODE_DEPTH = 64,
  parameter int MAX_STEPS  = 16,
  localparam int FEAT_W    = $clog2(N_FEAT),
  localparam int ADDR_W    = $clog2(NODE_DEPTH),
  localparam int VOTE_W    = $clog2(N_TREES + 1),
  localparam int NODE_W    = 2 + FEAT_W + 2 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [NODE_W-1:0] cfg_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              o,
  output logic [VOTE_W-1:0] votes,
  output logic              err
);

  localparam int TREE_W    = (N_TREES > 1) ? $clog2(N_TREES) : 1;
  localparam int STEP_W    = $clog2(MAX_STEPS + 1);
  localparam int STRIDE_SH = $clog2(NODE_DEPTH / N_TREES);
  localparam int FEAT_SPAN = 1 << FEAT_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [NODE_W-1:0] NODE_RST  = {1'b1, {(NODE_W-1){1'b0}}};
  localparam logic [VOTE_W:0]   TREES_REF = (VOTE_W + 1)'(N_TREES);

  logic [1:0]        state_q, state_d;
  logic [N_FEAT-1:0] i_q, i_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [TREE_W-1:0] tree_q, tree_d;
  logic [VOTE_W-1:0] vote_acc_q, vote_acc_d;
  logic              err_acc_q, err_acc_d;
  logic              o_q, o_d;
  logic [VOTE_W-1:0] votes_q, votes_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [NODE_W-1:0] mem_q [NODE_DEPTH];

  logic [NODE_W-1:0]    node_s;
  logic                 is_leaf_s;
  logic                 leaf_val_s;
  logic [FEAT_W-1:0]    feat_idx_s;
  logic [ADDR_W-1:0]    hi_s;
  logic [ADDR_W-1:0]    lo_s;
  logic [FEAT_SPAN-1:0] feat_pad_s;
  logic                 feat_bit_s;
  logic                 timeout_s;
  logic [VOTE_W-1:0]    vote_sum_s;
  logic [TREE_W-1:0]    tree_inc_s;
  logic [ADDR_W-1:0]    root_next_s;

  assign node_s      = mem_q[cur_q];
  assign is_leaf_s   = node_s[NODE_W-1];
  assign leaf_val_s  = node_s[NODE_W-2];
  assign feat_idx_s  = node_s[2*ADDR_W +: FEAT_W];
  assign hi_s        = node_s[ADDR_W +: ADDR_W];
  assign lo_s        = node_s[0 +: ADDR_W];
  // Zero-extending the features makes any feat_idx beyond N_FEAT read as 0.
  assign feat_pad_s  = FEAT_SPAN'(i_q);
  assign feat_bit_s  = feat_pad_s[feat_idx_s];
  assign timeout_s   = !is_leaf_s && (step_q == STEP_W'(MAX_STEPS));
  assign vote_sum_s  = vote_acc_q + VOTE_W'(is_leaf_s & leaf_val_s);
  assign tree_inc_s  = tree_q + TREE_W'(1);
  assign root_next_s = ADDR_W'(tree_inc_s) << STRIDE_SH;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign votes     = votes_q;
  assign err       = err_q;

  // Next-state logic for the accept / walk / present sequence.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    cur_d      = cur_q;
    step_d     = step_q;
    tree_d     = tree_q;
    vote_acc_d = vote_acc_q;
    err_acc_d  = err_acc_q;
    o_d        = o_q;
    votes_d    = votes_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          i_d        = i;
          vote_acc_d = '0;
          err_acc_d  = 1'b0;
          tree_d     = '0;
          cur_d      = '0;
          step_d     = STEP_W'(1);
          state_d    = WALK;
        end else begin
          state_d = IDLE;
        end
      end
      WALK: begin
        if (is_leaf_s || timeout_s) begin
          vote_acc_d = vote_sum_s;
          err_acc_d  = err_acc_q | timeout_s;
          if (tree_q == TREE_W'(N_TREES - 1)) begin
            votes_d = vote_sum_s;
            o_d     = {vote_sum_s, 1'b0} > TREES_REF;
            err_d   = err_acc_q | timeout_s;
            state_d = DONE;
          end else begin
            tree_d = tree_inc_s;
            cur_d  = root_next_s;
            step_d = STEP_W'(1);
          end
        end else begin
          step_d = step_q + STEP_W'(1);
          cur_d  = feat_bit_s ? hi_s : lo_s;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Control, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      cur_q       <= '0;
      step_q      <= '0;
      tree_q      <= '0;
      vote_acc_q  <= '0;
      err_acc_q   <= 1'b0;
      o_q         <= 1'b0;
      votes_q     <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      tree_q      <= tree_d;
      vote_acc_q  <= vote_acc_d;
      err_acc_q   <= err_acc_d;
      o_q         <= o_d;
      votes_q     <= votes_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Node table; writes land only while idle so an in-flight walk never sees a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NODE_DEPTH; k++) begin
        mem_q[k] <= NODE_RST;
      end
    end else if (cfg_we && (state_q == IDLE)) begin
      mem_q[cfg_addr] <= cfg_wdata;
    end
  end

endmodule

// File: tb/tb_dtree_seq_classifier.sv
// Self-checking bench for dtree_seq_classifier: directed sequences, a vector table
// and randomized tables/vectors checked against a tree-walking reference model.
module tb_dtree_seq_classifier;

  localparam int NF = 51;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = 6'd0;
  logic [19:0] cfg_wdata = 20'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [NF-1:0] i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        o;
  logic [2:0]  votes;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] tbl [64];

  typedef struct {
    logic [NF-1:0] vec;
    logic          exp_o;
    logic [2:0]    exp_votes;
    logic          exp_err;
    int            exp_lat;
  } vec_t;
  vec_t vt [6];

  dtree_seq_classifier dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .i(i), .out_valid(out_valid),
    .out_ready(out_ready), .o(o), .votes(votes), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input bit leaf, input bit val, input int feat,
                                     input int hi, input int lo);
    return {leaf, val, 6'(feat), 6'(hi), 6'(lo)};
  endfunction

  // Reference: walk each tree of the bench's table copy with plain loops.
  task automatic model(input logic [NF-1:0] v, output logic mo, output logic [2:0] mv,
                       output logic me, output int ml);
    int addr, cnt;
    logic [19:0] nd;
    cnt = 0; me = 1'b0; ml = 0;
    for (int t = 0; t < 4; t++) begin
      addr = t * 16;
      for (int s = 1; s <= 16; s++) begin
        nd = tbl[addr];
        ml++;
        if (nd[19]) begin
          cnt += int'(nd[18]);
          break;
        end
        if (s == 16) begin
          me = 1'b1;
          break;
        end
        if (int'(nd[17:12]) < NF && v[nd[17:12]]) addr = int'(nd[11:6]);
        else addr = int'(nd[5:0]);
      end
    end
    mv = 3'(cnt);
    mo = (2 * cnt > 4);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 64; k++) tbl[k] = mk(1, 0, 0, 0, 0);
  endtask

  task automatic cfg_write(input int addr, input logic [19:0] data);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_wdata = data;
    @(negedge clk); cfg_we = 1'b0;
    tbl[addr] = data;
  endtask

  task automatic wait_out(output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
  endtask

  task automatic run_exp(input string name, input logic [NF-1:0] v, input logic eo,
                         input logic [2:0] ev, input logic ee, input int el);
    int lat;
    bit busy_ok;
    @(negedge clk);
    chk({name, " in_ready idle"}, int'(in_ready), 1);
    in_valid = 1'b1; i = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat, busy_ok);
    chk({name, " o"}, int'(o), int'(eo));
    chk({name, " votes"}, int'(votes), int'(ev));
    chk({name, " err"}, int'(err), int'(ee));
    chk({name, " latency"}, lat, el);
    chk({name, " in_ready low while busy"}, int'(busy_ok), 1);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk({name, " released"}, int'({out_valid, in_ready}), 1);
  endtask

  task automatic run_model(input string name, input logic [NF-1:0] v);
    logic mo, me;
    logic [2:0] mv;
    int ml;
    model(v, mo, mv, me, ml);
    run_exp(name, v, mo, mv, me, ml);
  endtask

  initial begin
    logic [63:0] r;
    logic so, se;
    logic [2:0] sv;
    bit stable;
    int lat;
    bit busy_ok;

    vt[0] = '{vec: '0,                                exp_o: 1'b0, exp_votes: 3'd1, exp_err: 1'b0, exp_lat: 8};
    vt[1] = '{vec: '1,                                exp_o: 1'b1, exp_votes: 3'd3, exp_err: 1'b0, exp_lat: 7};
    vt[2] = '{vec: 51'd1 << 10,                       exp_o: 1'b0, exp_votes: 3'd2, exp_err: 1'b0, exp_lat: 8};
    vt[3] = '{vec: 51'd1,                             exp_o: 1'b0, exp_votes: 3'd2, exp_err: 1'b0, exp_lat: 8};
    vt[4] = '{vec: (51'd1 << 10) | (51'd1 << 50),     exp_o: 1'b1, exp_votes: 3'd3, exp_err: 1'b0, exp_lat: 7};
    vt[5] = '{vec: (51'd1 << 10) | 51'd1,             exp_o: 1'b1, exp_votes: 3'd3, exp_err: 1'b0, exp_lat: 8};

    for (int k = 0; k < 64; k++) tbl[k] = mk(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset o/votes/err", int'({o, votes, err}), 0);

    run_exp("default table", '0, 1'b0, 3'd0, 1'b0, 4);

    cfg_write(0, mk(0, 0, 10, 1, 2));
    cfg_write(1, mk(1, 1, 0, 0, 0));
    cfg_write(2, mk(1, 0, 0, 0, 0));
    run_exp("tree0 branch", 51'd1 << 10, 1'b0, 3'd1, 1'b0, 5);
    cfg_write(16, mk(1, 1, 0, 0, 0));
    cfg_write(32, mk(1, 1, 0, 0, 0));
    run_exp("majority", 51'd1 << 10, 1'b1, 3'd3, 1'b0, 5);

    // Hold the result with out_ready low; writes and in_valid must be ignored.
    @(negedge clk); in_valid = 1'b1; i = 51'd1 << 10;
    @(posedge clk); #1;
    wait_out(lat, busy_ok);
    so = o; sv = votes; se = err;
    chk("hold result votes", int'(sv), 3);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = mk(1, 0, 0, 0, 0);
      if (o !== so || votes !== sv || err !== se || !out_valid || in_ready) stable = 1'b0;
    end
    chk("hold stable", int'(stable), 1);
    @(negedge clk); cfg_we = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handshake to idle", int'({out_valid, in_ready}), 1);
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    chk("accept one cycle later", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_out(lat, busy_ok);
    chk("rerun after dropped write votes", int'(votes), 3);
    chk("rerun after dropped write o", int'(o), 1);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // Asynchronous reset during a long walk.
    cfg_write(48, mk(0, 0, 0, 48, 48));
    @(negedge clk); in_valid = 1'b1; i = '0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid-walk reset in_ready", int'(in_ready), 1);
    chk("mid-walk reset out_valid", int'(out_valid), 0);
    chk("mid-walk reset votes", int'(votes), 0);
    chk("mid-walk reset o", int'(o), 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 64; k++) tbl[k] = mk(1, 0, 0, 0, 0);
    run_exp("table restored", '0, 1'b0, 3'd0, 1'b0, 4);

    cfg_write(0, mk(0, 0, 10, 1, 2));
    cfg_write(1, mk(1, 1, 0, 0, 0));
    cfg_write(2, mk(1, 0, 0, 0, 0));
    cfg_write(16, mk(0, 0, 60, 17, 18));
    cfg_write(17, mk(1, 1, 0, 0, 0));
    cfg_write(18, mk(1, 0, 0, 0, 0));
    cfg_write(32, mk(0, 0, 50, 33, 34));
    cfg_write(33, mk(1, 1, 0, 0, 0));
    cfg_write(34, mk(0, 0, 0, 35, 36));
    cfg_write(35, mk(1, 1, 0, 0, 0));
    cfg_write(36, mk(1, 0, 0, 0, 0));
    cfg_write(48, mk(1, 1, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      run_exp($sformatf("vec%0d", k), vt[k].vec, vt[k].exp_o, vt[k].exp_votes,
              vt[k].exp_err, vt[k].exp_lat);

    do_reset();
    cfg_write(0, mk(1, 1, 0, 0, 0));
    cfg_write(16, mk(1, 1, 0, 0, 0));
    run_exp("tie", '0, 1'b0, 3'd2, 1'b0, 4);

    do_reset();
    cfg_write(48, mk(0, 0, 0, 48, 48));
    run_exp("loop timeout", '1, 1'b0, 3'd0, 1'b1, 19);

    for (int rt = 0; rt < 3; rt++) begin
      do_reset();
      for (int a = 0; a < 64; a++) begin
        if ($urandom_range(0, 2) == 0)
          cfg_write(a, mk(1, 1'($urandom_range(0, 1)), 0, 0, 0));
        else
          cfg_write(a, mk(0, 0, $urandom_range(0, 63), (a / 16) * 16 + $urandom_range(0, 15),
                          (a / 16) * 16 + $urandom_range(0, 15)));
      end
      for (int n = 0; n < 12; n++) begin
        r = {$urandom(), $urandom()};
        run_model($sformatf("rand t%0d v%0d", rt, n), r[NF-1:0]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
